// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
// Shared sizing constants and types for the general-purpose register file
// operand-fetch slice (gpr_operand_fetch and its gpr_scoreboard).
//   DATA_W    register width in bits
//   ADDR_W    register address width in bits
//   NUM_REGS  number of architectural registers (2**ADDR_W)
//   REG_ZERO  address of the hard-wired zero register
// -----------------------------------------------------------------------------
package gpr_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] gpr_addr_t;
    typedef logic [DATA_W-1:0] gpr_data_t;

    // One-hot decode of a register address into a per-register vector.
    function automatic logic [NUM_REGS-1:0] gpr_onehot(input gpr_addr_t addr);
        logic [NUM_REGS-1:0] vec;
        vec       = {NUM_REGS{1'b0}};
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage : gpr_pkg

// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
// Per-register pending vector that tracks in-flight producers, plus the
// combinational RAW/WAW hazard detection used to stall issue.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   rs_addr_i         source register 1 of the presented instruction
//   rt_addr_i         source register 2 of the presented instruction
//   dest_en_i         presented instruction writes a GPR
//   dest_addr_i       destination register of the presented instruction
//   wb_en_i           writeback strobe (clears pending for wb_addr_i)
//   wb_addr_i         writeback destination
//   set_en_i          instruction accepted this cycle (marks its dest pending)
//   hazard_o          presented instruction must stall
// -----------------------------------------------------------------------------
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W   = gpr_pkg::ADDR_W,
    parameter int NUM_REGS = gpr_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic              dest_en_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic              set_en_i,
    output logic              hazard_o
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] clr_vec_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic                dest_live_s;
    logic                rs_blocked_s;
    logic                rt_blocked_s;
    logic                waw_blocked_s;

    // Decode the writeback clear and the accept-time set into per-register vectors.
    always_comb begin
        clr_vec_s   = {NUM_REGS{1'b0}};
        set_vec_s   = {NUM_REGS{1'b0}};
        dest_live_s = dest_en_i && (dest_addr_i != ADDR_ZERO);
        if (wb_en_i) begin
            clr_vec_s[wb_addr_i] = 1'b1;
        end else begin
            clr_vec_s = {NUM_REGS{1'b0}};
        end
        if (set_en_i && dest_live_s) begin
            set_vec_s[dest_addr_i] = 1'b1;
        end else begin
            set_vec_s = {NUM_REGS{1'b0}};
        end
    end

    // Next pending state: set is applied after clear so a same-address set wins;
    // bit 0 is forced low because the zero register never has a producer.
    always_comb begin
        pending_d    = (pending_q & ~clr_vec_s) | set_vec_s;
        pending_d[0] = 1'b0;
    end

    // A register stops blocking in the very cycle its writeback arrives, since the
    // bypass delivers that value to the reader.
    always_comb begin
        rs_blocked_s  = pending_q[rs_addr_i] && !clr_vec_s[rs_addr_i];
        rt_blocked_s  = pending_q[rt_addr_i] && !clr_vec_s[rt_addr_i];
        waw_blocked_s = dest_live_s && pending_q[dest_addr_i] && !clr_vec_s[dest_addr_i];
        hazard_o      = rs_blocked_s || rt_blocked_s || waw_blocked_s;
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule : gpr_scoreboard

// File: rtl/gpr_operand_fetch.sv
// -----------------------------------------------------------------------------
// gpr_operand_fetch
// Read side of the general-purpose register file. Stores writeback results in a
// register array, stalls issue on RAW/WAW hazards through gpr_scoreboard,
// bypasses same-cycle writeback data to the readers, and presents operands to
// execute from a one-entry registered output with a valid/ready handshake.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   issue_valid     decoded instruction presented
//   issue_ready     instruction accepted when high together with issue_valid
//   rs_addr         source register 1
//   rt_addr         source register 2
//   dest_en         instruction will write a GPR
//   dest_addr       destination register
//   wb_en           writeback write strobe
//   wb_addr         writeback destination
//   gpr_data_in     writeback data
//   out_valid       operands valid toward execute
//   out_ready       execute consumes operands
//   rs_data         operand 1
//   rt_data         operand 2
//   out_dest_addr   registered destination (0 when dest_en was low)
// -----------------------------------------------------------------------------
module gpr_operand_fetch
    import gpr_pkg::*;
#(
    parameter int DATA_W   = gpr_pkg::DATA_W,
    parameter int ADDR_W   = gpr_pkg::ADDR_W,
    parameter int NUM_REGS = gpr_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              dest_en,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] gpr_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] out_dest_addr
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              out_valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [ADDR_W-1:0] out_dest_q;

    logic              hazard_s;
    logic              accept_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [ADDR_W-1:0] dest_val_s;

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .dest_en_i   (dest_en),
        .dest_addr_i (dest_addr),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .set_en_i    (accept_s),
        .hazard_o    (hazard_s)
    );

    // Handshake: a new operand set can be loaded when the output slot is empty
    // or is being drained in this same cycle.
    always_comb begin
        issue_ready = !hazard_s && (!out_valid_q || out_ready);
        accept_s    = issue_valid && issue_ready;
    end

    // Operand 1 read: zero register first, then writeback bypass, then array.
    always_comb begin
        rs_val_s = regs_q[rs_addr];
        if (rs_addr == ADDR_ZERO) begin
            rs_val_s = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_val_s = gpr_data_in;
        end else begin
            rs_val_s = regs_q[rs_addr];
        end
    end

    // Operand 2 read: zero register first, then writeback bypass, then array.
    always_comb begin
        rt_val_s = regs_q[rt_addr];
        if (rt_addr == ADDR_ZERO) begin
            rt_val_s = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_val_s = gpr_data_in;
        end else begin
            rt_val_s = regs_q[rt_addr];
        end
    end

    // Destination forwarded to execute is zeroed when the instruction does not write.
    always_comb begin
        if (dest_en) begin
            dest_val_s = dest_addr;
        end else begin
            dest_val_s = {ADDR_W{1'b0}};
        end
    end

    // Register array write port; the zero register is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en && (wb_addr != ADDR_ZERO)) begin
            regs_q[wb_addr] <= gpr_data_in;
        end
    end

    // One-entry output register: load on accept, drop valid when drained, and
    // otherwise hold the captured operands untouched by later writebacks.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rs_data_q   <= {DATA_W{1'b0}};
            rt_data_q   <= {DATA_W{1'b0}};
            out_dest_q  <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            out_valid_q <= 1'b1;
            rs_data_q   <= rs_val_s;
            rt_data_q   <= rt_val_s;
            out_dest_q  <= dest_val_s;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign rs_data       = rs_data_q;
    assign rt_data       = rt_data_q;
    assign out_dest_addr = out_dest_q;

endmodule : gpr_operand_fetch

// File: tb/tb_gpr_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_gpr_operand_fetch
// Directed scenarios plus a randomized run against a reference model of the
// register file, pending table and one-entry output slot.
// -----------------------------------------------------------------------------
module tb_gpr_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        dest_en;
    logic [4:0]  dest_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] gpr_data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  out_dest_addr;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ov;
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    logic [4:0]  m_dst;

    always #5 clk = ~clk;

    gpr_operand_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .dest_en       (dest_en),
        .dest_addr     (dest_addr),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .gpr_data_in   (gpr_data_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .out_dest_addr (out_dest_addr)
    );

    // Value an instruction would read right now.
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return gpr_data_in;
        return m_regs[a];
    endfunction

    // Register has an outstanding producer that is not retiring this cycle.
    function automatic bit m_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic bit m_ready();
        bit stall;
        stall = m_busy(rs_addr) || m_busy(rt_addr) || (dest_en && m_busy(dest_addr));
        return !stall && (!m_ov || out_ready);
    endfunction

    // Advance one clock, updating the model with the inputs present before the edge.
    task automatic tick();
        bit          acc;
        logic [31:0] nrs;
        logic [31:0] nrt;
        acc = issue_valid && m_ready();
        nrs = m_read(rs_addr);
        nrt = m_read(rt_addr);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_ov = 1'b0; m_rs = 32'd0; m_rt = 32'd0; m_dst = 5'd0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = gpr_data_in;
            if (wb_en) m_pend[wb_addr] = 1'b0;
            if (acc && dest_en && dest_addr != 5'd0) m_pend[dest_addr] = 1'b1;
            if (acc) begin
                m_ov = 1'b1; m_rs = nrs; m_rt = nrt;
                m_dst = dest_en ? dest_addr : 5'd0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        dest_en = 1'b0; dest_addr = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; gpr_data_in = 32'd0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_vec++; if (rs_data !== 32'd0) begin n_err++; $display("FAIL rst_rs: got %h want 0", rs_data); end
        n_vec++; if (rt_data !== 32'd0) begin n_err++; $display("FAIL rst_rt: got %h want 0", rt_data); end
        n_vec++; if (out_dest_addr !== 5'd0) begin n_err++; $display("FAIL rst_dest: got %0d want 0", out_dest_addr); end
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_write_read();
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; gpr_data_in = 32'hDEADBEEF;
        tick();
        idle();
        issue_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd0;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wr_valid: got %b want 1", out_valid); end
        n_vec++; if (rs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rs: got %h want deadbeef", rs_data); end
        n_vec++; if (rt_data !== 32'd0) begin n_err++; $display("FAIL wr_rt: got %h want 0", rt_data); end
    endtask

    task automatic test_raw_bypass();
        idle();
        issue_valid = 1'b1; dest_en = 1'b1; dest_addr = 5'd7;
        tick();
        idle();
        issue_valid = 1'b1; rs_addr = 5'd7;
        #1;
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b want 0", issue_ready); end
        wb_en = 1'b1; wb_addr = 5'd7; gpr_data_in = 32'h12345678;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (rs_data !== 32'h12345678) begin n_err++; $display("FAIL raw_bypass: got %h want 12345678", rs_data); end
        issue_valid = 1'b1; rt_addr = 5'd7;
        tick();
        idle();
        n_vec++; if (rt_data !== 32'h12345678) begin n_err++; $display("FAIL raw_array: got %h want 12345678", rt_data); end
    endtask

    task automatic test_reg_zero();
        idle();
        wb_en = 1'b1; wb_addr = 5'd0; gpr_data_in = 32'hFFFFFFFF;
        tick();
        idle();
        issue_valid = 1'b1; dest_en = 1'b1; dest_addr = 5'd0;
        tick();
        n_vec++; if (rs_data !== 32'd0) begin n_err++; $display("FAIL r0_read: got %h want 0", rs_data); end
        n_vec++; if (out_dest_addr !== 5'd0) begin n_err++; $display("FAIL r0_dest: got %0d want 0", out_dest_addr); end
        // Same-cycle write to r0 must neither bypass nor leave r0 pending.
        wb_en = 1'b1; wb_addr = 5'd0; gpr_data_in = 32'hFFFFFFFF;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL r0_pending: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (rs_data !== 32'd0) begin n_err++; $display("FAIL r0_bypass: got %h want 0", rs_data); end
    endtask

    task automatic test_hold();
        idle();
        tick();
        issue_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd7; out_ready = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_load: got %b want 1", out_valid); end
        rs_addr = 5'd0; rt_addr = 5'd5; dest_en = 1'b1; dest_addr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            wb_en = (i == 0); wb_addr = 5'd5; gpr_data_in = 32'hCAFEF00D;
            #1;
            n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", i, issue_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || rs_data !== 32'hDEADBEEF || rt_data !== 32'h12345678 || out_dest_addr !== 5'd0) begin
                n_err++; $display("FAIL hold_stable[%0d]: got v=%b rs=%h rt=%h d=%0d want v=1 rs=deadbeef rt=12345678 d=0", i, out_valid, rs_data, rt_data, out_dest_addr);
            end
        end
        wb_en = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL hold_release: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1 || rt_data !== 32'hCAFEF00D || out_dest_addr !== 5'd2) begin
            n_err++; $display("FAIL hold_next: got v=%b rt=%h d=%0d want v=1 rt=cafef00d d=2", out_valid, rt_data, out_dest_addr);
        end
        wb_en = 1'b1; wb_addr = 5'd2; gpr_data_in = 32'h2;
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_waw();
        idle();
        issue_valid = 1'b1; dest_en = 1'b1; dest_addr = 5'd9;
        tick();
        #1;
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", issue_ready); end
        tick();
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall2: got %b want 0", issue_ready); end
        wb_en = 1'b1; wb_addr = 5'd9; gpr_data_in = 32'h99;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_release: got %b want 1", issue_ready); end
        tick();
        idle();
        issue_valid = 1'b1; rs_addr = 5'd9;
        #1;
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_setwins: got %b want 0", issue_ready); end
        wb_en = 1'b1; wb_addr = 5'd9; gpr_data_in = 32'h9999;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_clear: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (rs_data !== 32'h9999) begin n_err++; $display("FAIL waw_data: got %h want 9999", rs_data); end
    endtask

    task automatic test_reset_mid();
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; gpr_data_in = 32'h33333333;
        tick();
        idle();
        issue_valid = 1'b1; dest_en = 1'b1; dest_addr = 5'd3; out_ready = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_loaded: got %b want 1", out_valid); end
        idle();
        out_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || out_dest_addr !== 5'd0) begin n_err++; $display("FAIL mid_clear: got v=%b d=%0d want v=0 d=0", out_valid, out_dest_addr); end
        issue_valid = 1'b1; rs_addr = 5'd3; out_ready = 1'b1;
        #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", issue_ready); end
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1 || rs_data !== 32'd0) begin n_err++; $display("FAIL mid_data: got v=%b rs=%h want v=1 rs=0", out_valid, rs_data); end
    endtask

    task automatic test_random();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 7));
            dest_en     = ($urandom_range(0, 4) < 3);
            dest_addr   = 5'($urandom_range(0, 7));
            wb_en       = ($urandom_range(0, 4) < 2);
            wb_addr     = 5'($urandom_range(0, 7));
            gpr_data_in = $urandom;
            out_ready   = ($urandom_range(0, 9) < 7);
            #1;
            n_vec++; if (issue_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, issue_ready, m_ready()); end
            tick();
            n_vec++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_ov); end
            if (m_ov) begin
                n_vec++; if (rs_data !== m_rs || rt_data !== m_rt || out_dest_addr !== m_dst) begin
                    n_err++; $display("FAIL rnd_data[%0d]: got rs=%h rt=%h d=%0d want rs=%h rt=%h d=%0d", i, rs_data, rt_data, out_dest_addr, m_rs, m_rt, m_dst);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_raw_bypass();
        test_reg_zero();
        test_hold();
        test_waw();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gpr_operand_fetch

// File: doc/gpr_operand_fetch.md
Name: gpr_operand_fetch

Overview:
- Read side of the general-purpose register file. The writeback stage's selected result (gpr_data_in) arrives on the write port; this block stores it and delivers rs/rt operands to execute.
- Contains a 32x32 register array, a per-register pending scoreboard for RAW/WAW hazard stalls, a same-cycle writeback bypass, and a one-entry registered output with a valid/ready handshake.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, register count; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decoded instruction presented.
- issue_ready  out  1  instruction accepted this cycle when high together with issue_valid.
- rs_addr  in  ADDR_W  source register 1.
- rt_addr  in  ADDR_W  source register 2.
- dest_en  in  1  instruction will write a GPR.
- dest_addr  in  ADDR_W  destination register.
- wb_en  in  1  writeback write strobe.
- wb_addr  in  ADDR_W  writeback destination.
- gpr_data_in  in  DATA_W  writeback data.
- out_valid  out  1  operands valid toward execute.
- out_ready  in  1  execute consumes operands.
- rs_data  out  DATA_W  operand 1.
- rt_data  out  DATA_W  operand 2.
- out_dest_addr  out  ADDR_W  registered dest_addr (0 when dest_en was low).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset state:
  - All registers = 0 and all pending bits = 0.
  - out_valid = 0; rs_data, rt_data and out_dest_addr = 0.
  - issue_ready is combinational and reads 1 in the first cycle after reset.
  - Reset mid-operation discards any held output and all pending state.
- Register 0:
  - Reads always return 0.
  - Writes to register 0 are ignored.
  - Register 0 is never marked pending.
- Write port: when wb_en is high and wb_addr != 0, gpr_data_in is written to the register array at the clock edge.
- Pending clear: when wb_en is high, pending[wb_addr] is cleared at the same edge. A writeback to a register that is not pending still writes the data; pending is left unchanged.
- Bypass: a read of wb_addr in the same cycle as a writeback returns gpr_data_in, not the stale array value.
- Hazard (combinational):
  - A source is blocked when it is pending and not being written back this cycle.
  - hazard = (rs blocked) OR (rt blocked) OR (dest_en AND dest_addr != 0 AND pending[dest_addr] AND NOT cleared this cycle). The last term is the WAW condition, so at most one producer is outstanding per register.
- issue_ready = NOT hazard AND (NOT out_valid OR out_ready).
- Accept: issue_valid AND issue_ready.
  - On accept, operands are registered and out_valid = 1 on the next cycle. Latency is 1 cycle.
  - If dest_en AND dest_addr != 0, pending[dest_addr] is set.
  - Set/clear of the same address in one cycle: set wins.
- Output hold:
  - While out_valid AND NOT out_ready, rs_data, rt_data and out_dest_addr hold stable.
  - Held data is not refreshed by later writebacks; it was correct when captured.
- Output release: out_valid drops when out_ready is high and no new accept occurs. Back-to-back accepts give one transfer per cycle.
- No state machine beyond the out_valid flag and the pending vector. The pending vector is NUM_REGS bits with bit 0 tied to 0.

Decomposition:
- Package gpr_pkg:
  - DATA_W, ADDR_W, NUM_REGS.
  - REG_ZERO localparam.
  - typedef gpr_addr_t (logic [ADDR_W-1:0]) and gpr_data_t.
- Sub-module gpr_scoreboard:
  - Holds the pending vector and its set/clear logic.
  - Computes hazard from rs/rt/dest and the wb strobe.
- The register array, bypass and output register stay in the top.

Test Plan:
- Reset, then wb_en=1, wb_addr=5, data=0xDEADBEEF; next cycle issue rs=5, rt=0 -> one cycle later out_valid=1, rs_data=0xDEADBEEF, rt_data=0.
- Issue dest_en=1, dest=7; next cycle issue rs=7 -> issue_ready=0. Assert wb_en, wb_addr=7, data=0x12345678 that cycle -> issue_ready=1 and rs_data=0x12345678 (bypass).
- Write 0xFFFFFFFF to register 0, then read rs=0 -> rs_data=0, and pending[0] never set.
- Hold out_ready=0 for 3 cycles with issue_valid=1 -> issue_ready=0, outputs stable. Raise out_ready -> transfer, next instruction accepted the same cycle.
- WAW: dest=9 pending, new issue with dest=9 -> stall until wb_addr=9. Same-cycle wb_addr=9 and new accept with dest=9 -> pending[9]=1 afterwards.
- Assert reset with out_valid=1 and pending[3]=1 -> next cycle out_valid=0, pending clear, issue rs=3 accepted immediately with rs_data=0.
